// File: rtl/beam_thresh_pkg.sv
// beam_thresh_pkg
// Shared constants and FSM state encoding for the beamformer threshold loader.
//   THRESH_BITS_DEFAULT : default threshold width
//   THRESH_OFF          : shadow reset value; an all-ones threshold never fires
//   BEAM_ADDR_BITS      : width of the beam index / register address
//   fsm_state_t         : sequencer state (IDLE, LOAD, GAP, UPDATE)
package beam_thresh_pkg;

   localparam int          THRESH_BITS_DEFAULT = 18;
   localparam logic [17:0] THRESH_OFF          = 18'h3FFFF;
   localparam int          BEAM_ADDR_BITS      = 6;

   typedef logic [1:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE   = 2'd0;
   localparam fsm_state_t ST_LOAD   = 2'd1;
   localparam fsm_state_t ST_GAP    = 2'd2;
   localparam fsm_state_t ST_UPDATE = 2'd3;

endpackage

// File: rtl/beam_thresh_shadow.sv
// beam_thresh_shadow
// NBEAMS x THRESH_BITS shadow register bank written by firmware at any time.
// Optional feature macro: BEAM_THRESH_READBACK_EN (registered readback port).
//   clk_i, rst_i  : clock, synchronous active-high reset (bank -> DEFAULT_THRESH)
//   wr_i          : write strobe
//   wr_addr_i     : write (and readback) beam index
//   wr_dat_i      : write data
//   wr_ok_o       : wr_addr_i is a valid beam index (combinational)
//   seq_idx_i     : sequencer read index (combinational read)
//   seq_dat_o     : shadow[seq_idx_i]
//   rd_dat_o      : (readback only) shadow[wr_addr_i] one cycle later, 0 if out of range
module beam_thresh_shadow
   import beam_thresh_pkg::*;
#(
   parameter int                     NBEAMS         = 2,
   parameter int                     THRESH_BITS    = THRESH_BITS_DEFAULT,
   parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = THRESH_BITS'(THRESH_OFF)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wr_i,
   input  logic [BEAM_ADDR_BITS-1:0] wr_addr_i,
   input  logic [THRESH_BITS-1:0]    wr_dat_i,
   output logic                      wr_ok_o,
   input  logic [BEAM_ADDR_BITS-1:0] seq_idx_i,
   output logic [THRESH_BITS-1:0]    seq_dat_o
`ifdef BEAM_THRESH_READBACK_EN
   ,output logic [THRESH_BITS-1:0]   rd_dat_o
`endif
);

   logic [THRESH_BITS-1:0] r_bank [NBEAMS];

   assign wr_ok_o = ({1'b0, wr_addr_i} < (BEAM_ADDR_BITS+1)'(NBEAMS));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NBEAMS; i++) r_bank[i] <= DEFAULT_THRESH;
      end else if (wr_i && wr_ok_o) begin
         for (int i = 0; i < NBEAMS; i++) begin
            if (wr_addr_i == BEAM_ADDR_BITS'(i)) r_bank[i] <= wr_dat_i;
         end
      end
   end

   // Explicit compare mux keeps the 6-bit index from over-addressing a small bank.
   always_comb begin
      seq_dat_o = '0;
      for (int i = 0; i < NBEAMS; i++) begin
         if (seq_idx_i == BEAM_ADDR_BITS'(i)) seq_dat_o = r_bank[i];
      end
   end

`ifdef BEAM_THRESH_READBACK_EN
   logic [THRESH_BITS-1:0] w_rd;
   logic [THRESH_BITS-1:0] r_rd;

   always_comb begin
      w_rd = '0;
      for (int i = 0; i < NBEAMS; i++) begin
         if (wr_addr_i == BEAM_ADDR_BITS'(i)) w_rd = r_bank[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_rd <= '0;
      else       r_rd <= w_rd;
   end

   assign rd_dat_o = r_rd;
`endif

endmodule

// File: rtl/beam_threshold_loader.sv
// beam_threshold_loader
// Writer side of the beamformer threshold interface. Keeps a shadow threshold
// bank and, on request, streams it to the beamformer one beam per clock on
// thresh_o/thresh_ce_o, then issues a single update_o strobe.
// Optional feature macro: BEAM_THRESH_READBACK_EN (adds thr_rd_o).
//   clk_i, rst_i : clock, synchronous active-high reset
//   thr_wr_i     : shadow write strobe
//   thr_addr_i   : beam index for write / readback
//   thr_dat_i    : shadow write data
//   load_i       : load request, level sampled every clock
//   busy_o       : load sequence in progress
//   done_o       : one-cycle pulse after update_o
//   wr_err_o     : sticky, write to out-of-range beam
//   thresh_o     : threshold value to beamformer (holds when idle)
//   thresh_ce_o  : one-hot per-beam capture enable
//   update_o     : one-cycle apply strobe
//   thr_rd_o     : (readback only) shadow[thr_addr_i], one-cycle latency
//
// state   | meaning
// IDLE    | waiting for load_i
// LOAD    | emitting beam r_k on thresh_o / thresh_ce_o
// GAP     | quiet cycles before the apply strobe
// UPDATE  | update_o high; restart if a request is pending
module beam_threshold_loader
   import beam_thresh_pkg::*;
#(
   parameter int                     NBEAMS         = 2,
   parameter int                     THRESH_BITS    = THRESH_BITS_DEFAULT,
   parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = THRESH_BITS'(THRESH_OFF),
   parameter int                     UPDATE_GAP     = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      thr_wr_i,
   input  logic [BEAM_ADDR_BITS-1:0] thr_addr_i,
   input  logic [THRESH_BITS-1:0]    thr_dat_i,
   input  logic                      load_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      wr_err_o,
   output logic [THRESH_BITS-1:0]    thresh_o,
   output logic [NBEAMS-1:0]         thresh_ce_o,
   output logic                      update_o
`ifdef BEAM_THRESH_READBACK_EN
   ,output logic [THRESH_BITS-1:0]   thr_rd_o
`endif
);

   localparam logic [BEAM_ADDR_BITS-1:0] K_LAST   = BEAM_ADDR_BITS'(NBEAMS - 1);
   localparam logic [3:0]                GAP_LOAD = 4'(UPDATE_GAP - 1);

   fsm_state_t                r_state;
   logic [BEAM_ADDR_BITS-1:0] r_k;
   logic [3:0]                r_gap_cnt;
   logic                      r_pending;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_update;
   logic                      r_wr_err;
   logic [THRESH_BITS-1:0]    r_thresh;
   logic [NBEAMS-1:0]         r_ce;

   fsm_state_t                w_state_nxt;
   logic [BEAM_ADDR_BITS-1:0] w_k_nxt;
   logic [3:0]                w_gap_nxt;
   logic                      w_pend_nxt;
   logic [NBEAMS-1:0]         w_ce_nxt;
   logic [THRESH_BITS-1:0]    w_seq_dat;
   logic                      w_wr_ok;

   beam_thresh_shadow #(
      .NBEAMS         (NBEAMS),
      .THRESH_BITS    (THRESH_BITS),
      .DEFAULT_THRESH (DEFAULT_THRESH)
   ) u_shadow (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_i      (thr_wr_i),
      .wr_addr_i (thr_addr_i),
      .wr_dat_i  (thr_dat_i),
      .wr_ok_o   (w_wr_ok),
      .seq_idx_i (w_k_nxt),
      .seq_dat_o (w_seq_dat)
`ifdef BEAM_THRESH_READBACK_EN
      ,.rd_dat_o (thr_rd_o)
`endif
   );

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_gap_nxt   = r_gap_cnt;
      w_pend_nxt  = r_pending;
      case (r_state)
         ST_IDLE: begin
            if (load_i) begin
               w_state_nxt = ST_LOAD;
               w_k_nxt     = '0;
            end
         end
         ST_LOAD: begin
            if (load_i) w_pend_nxt = 1'b1;
            if (r_k == K_LAST) begin
               if (UPDATE_GAP == 0) begin
                  w_state_nxt = ST_UPDATE;
               end else begin
                  w_state_nxt = ST_GAP;
                  w_gap_nxt   = GAP_LOAD;
               end
            end else begin
               w_k_nxt = r_k + 1'b1;
            end
         end
         ST_GAP: begin
            if (load_i) w_pend_nxt = 1'b1;
            if (r_gap_cnt == 4'd0) w_state_nxt = ST_UPDATE;
            else                   w_gap_nxt   = r_gap_cnt - 1'b1;
         end
         ST_UPDATE: begin
            // A request arriving in the UPDATE cycle itself is folded into
            // the pending flag so it restarts without passing through IDLE.
            if (r_pending || load_i) begin
               w_state_nxt = ST_LOAD;
               w_k_nxt     = '0;
               w_pend_nxt  = 1'b0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ce_nxt = '0;
      if (w_state_nxt == ST_LOAD) begin
         for (int i = 0; i < NBEAMS; i++) w_ce_nxt[i] = (w_k_nxt == BEAM_ADDR_BITS'(i));
      end
   end

   // Outputs are registered from the next-state decode so each output cycle
   // matches the state register for that same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_gap_cnt <= '0;
         r_pending <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_update  <= 1'b0;
         r_wr_err  <= 1'b0;
         r_thresh  <= '0;
         r_ce      <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_k       <= w_k_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_pending <= w_pend_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= (r_state == ST_UPDATE);
         r_update  <= (w_state_nxt == ST_UPDATE);
         r_ce      <= w_ce_nxt;
         if (w_state_nxt == ST_LOAD) r_thresh <= w_seq_dat;
         if (thr_wr_i && !w_wr_ok)   r_wr_err <= 1'b1;
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign wr_err_o    = r_wr_err;
   assign thresh_o    = r_thresh;
   assign thresh_ce_o = r_ce;
   assign update_o    = r_update;

endmodule

// File: tb/tb_beam_threshold_loader.sv
module tb_beam_threshold_loader;

   logic        clk_i;
   logic        rst_i;
   logic        thr_wr_i;
   logic [5:0]  thr_addr_i;
   logic [17:0] thr_dat_i;
   logic        load_i;
   logic        busy_o;
   logic        done_o;
   logic        wr_err_o;
   logic [17:0] thresh_o;
   logic [3:0]  thresh_ce_o;
   logic        update_o;
`ifdef BEAM_THRESH_READBACK_EN
   logic [17:0] thr_rd_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   beam_threshold_loader #(
      .NBEAMS     (4),
      .UPDATE_GAP (2)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .thr_wr_i    (thr_wr_i),
      .thr_addr_i  (thr_addr_i),
      .thr_dat_i   (thr_dat_i),
      .load_i      (load_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .wr_err_o    (wr_err_o),
      .thresh_o    (thresh_o),
      .thresh_ce_o (thresh_ce_o),
      .update_o    (update_o)
`ifdef BEAM_THRESH_READBACK_EN
      ,.thr_rd_o   (thr_rd_o)
`endif
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called in the first cycle of a pass (load sampled at the previous edge).
   // Walks the 7 cycles LOAD x4, GAP x2, UPDATE, checking every output, and
   // optionally pulses load_i / a shadow write in chosen cycles.
   // Returns in the cycle after update_o.
   task automatic expect_pass(input logic [17:0] a, input logic [17:0] b,
                              input logic [17:0] c, input logic [17:0] d,
                              input logic done_first, input logic [6:0] ld_mask,
                              input int wr_j, input logic [5:0] wr_a,
                              input logic [17:0] wr_d);
      logic [17:0] v [4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int j = 0; j < 7; j++) begin
         check($sformatf("ce[%0d]", j), 32'(thresh_ce_o), (j < 4) ? (32'd1 << j) : 32'd0);
         check($sformatf("thresh[%0d]", j), 32'(thresh_o), (j < 4) ? 32'(v[j]) : 32'(v[3]));
         check($sformatf("update[%0d]", j), 32'(update_o), (j == 6) ? 32'd1 : 32'd0);
         check($sformatf("busy[%0d]", j), 32'(busy_o), 32'd1);
         check($sformatf("done[%0d]", j), 32'(done_o), (j == 0) ? 32'(done_first) : 32'd0);
         load_i = ld_mask[j];
         if (j == wr_j) begin
            thr_wr_i   = 1'b1;
            thr_addr_i = wr_a;
            thr_dat_i  = wr_d;
         end
         step();
         load_i   = 1'b0;
         thr_wr_i = 1'b0;
      end
   endtask

   task automatic expect_done_then_idle();
      check("done_pulse", 32'(done_o), 32'd1);
      check("busy_after", 32'(busy_o), 32'd0);
      check("upd_after", 32'(update_o), 32'd0);
      check("ce_after", 32'(thresh_ce_o), 32'd0);
      step();
      check("done_clear", 32'(done_o), 32'd0);
      check("busy_idle", 32'(busy_o), 32'd0);
   endtask

   task automatic write_shadow(input logic [5:0] addr, input logic [17:0] dat);
      thr_wr_i   = 1'b1;
      thr_addr_i = addr;
      thr_dat_i  = dat;
      step();
      thr_wr_i = 1'b0;
   endtask

   task automatic pulse_load();
      load_i = 1'b1;
      step();
      load_i = 1'b0;
   endtask

   initial begin
      rst_i      = 1'b1;
      thr_wr_i   = 1'b0;
      thr_addr_i = '0;
      thr_dat_i  = '0;
      load_i     = 1'b0;
      step();
      step();
      rst_i = 1'b0;

      // reset state
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_werr", 32'(wr_err_o), 32'd0);
      check("rst_thresh", 32'(thresh_o), 32'd0);
      check("rst_ce", 32'(thresh_ce_o), 32'd0);
      check("rst_upd", 32'(update_o), 32'd0);

      // default shadow pass
      pulse_load();
      expect_pass(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1'b0, 7'b0, -1, 6'd0, 18'd0);
      expect_done_then_idle();

      // basic load
      write_shadow(6'd0, 18'd100);
      write_shadow(6'd1, 18'd200);
      write_shadow(6'd2, 18'd300);
      write_shadow(6'd3, 18'd400);
      check("no_werr", 32'(wr_err_o), 32'd0);
      pulse_load();
      expect_pass(18'd100, 18'd200, 18'd300, 18'd400, 1'b0, 7'b0, -1, 6'd0, 18'd0);
      expect_done_then_idle();

      // collision: beam2 written at the edge it is registered -> old value
      pulse_load();
      expect_pass(18'd100, 18'd200, 18'd300, 18'd400, 1'b0, 7'b0, 1, 6'd2, 18'd555);
      expect_done_then_idle();
      pulse_load();
      expect_pass(18'd100, 18'd200, 18'd555, 18'd400, 1'b0, 7'b0, -1, 6'd0, 18'd0);
      expect_done_then_idle();

      // pending: load pulsed in GAP and in UPDATE -> exactly one extra pass
      pulse_load();
      expect_pass(18'd100, 18'd200, 18'd555, 18'd400, 1'b0, 7'b1010000, -1, 6'd0, 18'd0);
      expect_pass(18'd100, 18'd200, 18'd555, 18'd400, 1'b1, 7'b0, -1, 6'd0, 18'd0);
      expect_done_then_idle();
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("no_third_pass[%0d]", i), {30'd0, busy_o, update_o}, 32'd0);
      end

      // abort: reset while thresh_ce_o[1] is high
      pulse_load();
      step();
      check("abort_ce1", 32'(thresh_ce_o), 32'd2);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("abort_ce", 32'(thresh_ce_o), 32'd0);
      check("abort_thresh", 32'(thresh_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      check("abort_upd", 32'(update_o), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("abort_no_upd[%0d]", i), {30'd0, update_o, busy_o}, 32'd0);
      end
      pulse_load();
      expect_pass(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1'b0, 7'b0, -1, 6'd0, 18'd0);
      expect_done_then_idle();

      // out-of-range write: sticky error until reset
      write_shadow(6'd4, 18'h00777);
      check("werr_set", 32'(wr_err_o), 32'd1);
      write_shadow(6'd0, 18'd1);
      step();
      step();
      check("werr_sticky", 32'(wr_err_o), 32'd1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("werr_clr", 32'(wr_err_o), 32'd0);

`ifdef BEAM_THRESH_READBACK_EN
      write_shadow(6'd1, 18'h12345);
      check("rd_n1", 32'(thr_rd_o), 32'h3FFFF);
      step();
      check("rd_n2", 32'(thr_rd_o), 32'h12345);
      thr_addr_i = 6'd9;
      step();
      check("rd_oor", 32'(thr_rd_o), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
